// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, transmitter FSM states and frame helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic parity_on(input logic [1:0] mode);
    case (mode)
      PAR_EVEN: return 1'b1;
      PAR_ODD:  return 1'b1;
      PAR_NONE: return 1'b0;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

  // Bits per frame: start + data + optional parity + one or two stops.
  function automatic int frame_bits(input int data_w, input logic [1:0] mode, input logic two_stop);
    return 1 + data_w + (parity_on(mode) ? 1 : 0) + (two_stop ? 2 : 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO; divisor, parity and stop config are latched per frame at pop.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  input  logic                        tx_enable,
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  input  logic                        err_clear,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow_err
);
  import uart_pkg::*;

  localparam int BIT_W = $clog2(DATA_W);

  tx_state_e         state_r, state_n;
  logic [DIV_W-1:0]  baud_cnt_r, baud_cnt_n, div_r, div_n;
  logic [BIT_W-1:0]  bit_idx_r, bit_idx_n;
  logic [DATA_W-1:0] shift_r, shift_n, fifo_data_s;
  logic [1:0]        mode_r, mode_n;
  logic              par_acc_r, par_acc_n, stop2_r, stop2_n;
  logic              tx_out_r, tx_out_n, tx_busy_r, tx_busy_n, overflow_r, overflow_n;
  logic              fifo_pop_s, fifo_full_s, fifo_empty_s, start_ok_s, bit_end_s, load_s;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_valid), .push_data(wr_data),
    .pop(fifo_pop_s), .pop_data(fifo_data_s), .full(fifo_full_s),
    .empty(fifo_empty_s), .count(fifo_count)
  );

  assign wr_ready     = ~fifo_full_s;
  assign tx_out       = tx_out_r;
  assign tx_busy      = tx_busy_r;
  assign overflow_err = overflow_r;
  assign start_ok_s   = tx_enable & ~fifo_empty_s;
  assign bit_end_s    = (baud_cnt_r == '0);

  // State register: reset forces the line high and aborts any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;   baud_cnt_r <= '0;   div_r <= '0;     bit_idx_r <= '0;
      shift_r <= '0;        par_acc_r <= 1'b0;  mode_r <= PAR_NONE; stop2_r <= 1'b0;
      tx_out_r <= 1'b1;     tx_busy_r <= 1'b0;  overflow_r <= 1'b0;
    end else begin
      state_r <= state_n;   baud_cnt_r <= baud_cnt_n; div_r <= div_n; bit_idx_r <= bit_idx_n;
      shift_r <= shift_n;   par_acc_r <= par_acc_n;   mode_r <= mode_n; stop2_r <= stop2_n;
      tx_out_r <= tx_out_n; tx_busy_r <= tx_busy_n;   overflow_r <= overflow_n;
    end
  end

  // Next-state logic; a pop at the end of the last stop bit restarts with no idle gap.
  always_comb begin
    state_n = state_r;  div_n = div_r;  bit_idx_n = bit_idx_r;  shift_n = shift_r;
    par_acc_n = par_acc_r;  mode_n = mode_r;  stop2_n = stop2_r;
    load_s = 1'b0;  fifo_pop_s = 1'b0;
    if (state_r != ST_IDLE) begin
      baud_cnt_n = bit_end_s ? div_r : baud_cnt_r - DIV_W'(1);
    end else begin
      baud_cnt_n = baud_cnt_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) load_s = 1'b1;
        else            state_n = ST_IDLE;
      end
      ST_START: begin
        if (bit_end_s) begin
          state_n   = ST_DATA;
          bit_idx_n = '0;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_n = shift_r >> 1;
          if (bit_idx_r == BIT_W'(DATA_W-1)) begin
            bit_idx_n = '0;
            state_n   = parity_on(mode_r) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_n = bit_idx_r + BIT_W'(1);
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_n   = ST_STOP;
          bit_idx_n = '0;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (stop2_r && (bit_idx_r == '0)) bit_idx_n = BIT_W'(1);
          else if (start_ok_s)              load_s = 1'b1;
          else                              state_n = ST_IDLE;
        end else begin
          state_n = ST_STOP;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (load_s) begin
      fifo_pop_s = 1'b1;           state_n = ST_START;     shift_n = fifo_data_s;
      par_acc_n  = ^fifo_data_s;   div_n = baud_div;       baud_cnt_n = baud_div;
      mode_n     = parity_mode;    stop2_n = stop2;        bit_idx_n = '0;
    end else begin
      fifo_pop_s = 1'b0;
    end
  end

  // Output logic evaluated on the next state so tx_out is registered without a cycle of lag.
  always_comb begin
    tx_out_n  = 1'b1;
    tx_busy_n = 1'b1;
    case (state_n)
      ST_IDLE:   begin tx_out_n = 1'b1; tx_busy_n = 1'b0; end
      ST_START:  tx_out_n = 1'b0;
      ST_DATA:   tx_out_n = shift_n[0];
      ST_PARITY: tx_out_n = parity_bit(mode_n, par_acc_n);
      ST_STOP:   tx_out_n = 1'b1;
      default:   begin tx_out_n = 1'b1; tx_busy_n = 1'b0; end
    endcase
    if (wr_valid && fifo_full_s) overflow_n = 1'b1;
    else if (err_clear)          overflow_n = 1'b0;
    else                         overflow_n = overflow_r;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (8-bit instance plus a 5-bit instance for short frames).
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2, tx_enable, wr_valid, err_clear;
  logic [7:0]  wr_data;
  logic        wr_ready, tx_out, tx_busy, overflow_err;
  logic [4:0]  fifo_count;

  logic [15:0] b_baud_div;
  logic [1:0]  b_parity_mode;
  logic        b_stop2, b_tx_enable, b_wr_valid, b_err_clear;
  logic [4:0]  b_wr_data;
  logic        b_wr_ready, b_tx_out, b_tx_busy, b_overflow_err;
  logic [4:0]  b_fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .tx_enable(tx_enable), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .err_clear(err_clear), .tx_out(tx_out), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(16), .DIV_W(16)) dut5 (
    .clk(clk), .reset(reset), .baud_div(b_baud_div), .parity_mode(b_parity_mode),
    .stop2(b_stop2), .tx_enable(b_tx_enable), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
    .wr_ready(b_wr_ready), .err_clear(b_err_clear), .tx_out(b_tx_out), .tx_busy(b_tx_busy),
    .fifo_count(b_fifo_count), .overflow_err(b_overflow_err)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
    checks++; if (b_tx_out !== 1'b1) begin errors++; $display("FAIL reset_b_tx_out: got %b want 1", b_tx_out); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0; tx_enable = 1'b1;
    wr_data = 8'hA5; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL latency_count: got %0d want 1", fifo_count); end
    checks++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin errors++; $display("FAIL latency_idle: busy=%b tx=%b want 0/1", tx_busy, tx_out); end
    tick(1);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL pop_count: got %0d want 0", fifo_count); end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (tx_out !== frame[k/4] || tx_busy !== 1'b1) begin
        errors++; $display("FAIL basic_frame cycle %0d: tx=%b busy=%b want tx=%b busy=1", k, tx_out, tx_busy, frame[k/4]);
      end
      tick(1);
    end
    checks++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin errors++; $display("FAIL basic_end: busy=%b tx=%b want 0/1", tx_busy, tx_out); end
  endtask

  task automatic test_parity();
    logic [11:0] frames [3];
    int          lens   [3];
    logic [1:0]  modes  [3];
    logic        s2     [3];
    frames[0] = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}; lens[0] = 11; modes[0] = 2'b01; s2[0] = 1'b0;
    frames[1] = {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}; lens[1] = 11; modes[1] = 2'b10; s2[1] = 1'b0;
    frames[2] = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}; lens[2] = 12; modes[2] = 2'b01; s2[2] = 1'b1;
    baud_div = 16'd3; tx_enable = 1'b1;
    for (int t = 0; t < 3; t++) begin
      parity_mode = modes[t]; stop2 = s2[t]; wr_data = 8'h07; wr_valid = 1'b1;
      tick(1);
      wr_valid = 1'b0;
      tick(1);
      for (int k = 0; k < lens[t] * 4; k++) begin
        checks++;
        if (tx_out !== frames[t][k/4] || tx_busy !== 1'b1) begin
          errors++; $display("FAIL parity_frame case %0d cycle %0d: tx=%b busy=%b want tx=%b busy=1", t, k, tx_out, tx_busy, frames[t][k/4]);
        end
        tick(1);
      end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL parity_end case %0d: busy=%b want 0", t, tx_busy); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] word;
    logic       exp_bit;
    int         j, c;
    tx_enable = 1'b0; baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h10 + 8'(i); wr_valid = 1'b1;
      tick(1);
    end
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", fifo_count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b want 0", overflow_err); end
    wr_data = 8'hEE; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", overflow_err); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", fifo_count); end
    err_clear = 1'b1;
    tick(1);
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", overflow_err); end
    wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0; err_clear = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_set_wins: got %b want 1", overflow_err); end
    tx_enable = 1'b1;
    tick(1);
    checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL first_pop_count: got %0d want 15", fifo_count); end
    for (int k = 0; k < 160; k++) begin
      j = k / 10; c = k % 10;
      word = 8'h10 + 8'(j);
      exp_bit = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : word[c-1];
      checks++;
      if (tx_out !== exp_bit || tx_busy !== 1'b1) begin
        errors++; $display("FAIL b2b frame %0d bit %0d: tx=%b busy=%b want tx=%b busy=1", j, c, tx_out, tx_busy, exp_bit);
      end
      tick(1);
    end
    checks++; if (tx_busy !== 1'b0 || fifo_count !== 5'd0 || tx_out !== 1'b1) begin
      errors++; $display("FAIL b2b_end: busy=%b count=%0d tx=%b want 0/0/1", tx_busy, fifo_count, tx_out);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    tx_enable = 1'b0; baud_div = 16'd0;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h40 + 8'(i); wr_valid = 1'b1;
      tick(1);
    end
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL simul_pre_count: got %0d want 5", fifo_count); end
    wr_data = 8'h4F; wr_valid = 1'b1; tx_enable = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL simul_count: got %0d want 5", fifo_count); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL simul_busy: got %b want 1", tx_busy); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", overflow_err); end
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", overflow_err); end
    n = 0;
    while ((tx_busy !== 1'b0 || fifo_count !== 5'd0) && n < 400) begin
      tick(1);
      n++;
    end
    checks++; if (tx_busy !== 1'b0 || fifo_count !== 5'd0) begin
      errors++; $display("FAIL drain_timeout: busy=%b count=%0d want 0/0", tx_busy, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] frame;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0; tx_enable = 1'b1;
    wr_data = 8'h52; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    tick(1);
    wr_data = 8'h33; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL mid_queued: got %0d want 1", fifo_count); end
    tick(15);
    checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b want 0", tx_out); end
    tick(1);
    #2 reset = 1'b1;
    #1;
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL async_tx_out: got %b want 1", tx_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", tx_busy); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL async_count: got %0d want 0", fifo_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);
    checks++; if (tx_busy !== 1'b0 || tx_out !== 1'b1 || fifo_count !== 5'd0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b tx=%b count=%0d want 0/1/0", tx_busy, tx_out, fifo_count);
    end
    frame = {1'b1, 8'hC3, 1'b0};
    wr_data = 8'hC3; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    tick(1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (tx_out !== frame[k/4] || tx_busy !== 1'b1) begin
        errors++; $display("FAIL clean_frame cycle %0d: tx=%b busy=%b want tx=%b busy=1", k, tx_out, tx_busy, frame[k/4]);
      end
      tick(1);
    end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL clean_end: busy=%b want 0", tx_busy); end
  endtask

  task automatic test_short_frame();
    logic [6:0] frame;
    b_baud_div = 16'd0; b_parity_mode = 2'b00; b_stop2 = 1'b0; b_tx_enable = 1'b1;
    frame = {1'b1, 5'h16, 1'b0};
    b_wr_data = 5'h16; b_wr_valid = 1'b1;
    tick(1);
    b_wr_valid = 1'b0;
    tick(1);
    b_baud_div = 16'd2;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (b_tx_out !== frame[k] || b_tx_busy !== 1'b1) begin
        errors++; $display("FAIL short_frame cycle %0d: tx=%b busy=%b want tx=%b busy=1", k, b_tx_out, b_tx_busy, frame[k]);
      end
      tick(1);
    end
    checks++; if (b_tx_busy !== 1'b0) begin errors++; $display("FAIL short_end: busy=%b want 0", b_tx_busy); end
    frame = {1'b1, 5'h01, 1'b0};
    b_wr_data = 5'h01; b_wr_valid = 1'b1;
    tick(1);
    b_wr_valid = 1'b0;
    tick(1);
    for (int k = 0; k < 21; k++) begin
      checks++;
      if (b_tx_out !== frame[k/3] || b_tx_busy !== 1'b1) begin
        errors++; $display("FAIL div2_frame cycle %0d: tx=%b busy=%b want tx=%b busy=1", k, b_tx_out, b_tx_busy, frame[k/3]);
      end
      tick(1);
    end
    checks++; if (b_tx_busy !== 1'b0) begin errors++; $display("FAIL div2_end: busy=%b want 0", b_tx_busy); end
  endtask

  initial begin
    reset = 1'b1;
    baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0; tx_enable = 1'b0;
    wr_valid = 1'b0; wr_data = 8'h00; err_clear = 1'b0;
    b_baud_div = 16'd0; b_parity_mode = 2'b00; b_stop2 = 1'b0; b_tx_enable = 1'b0;
    b_wr_valid = 1'b0; b_wr_data = 5'h00; b_err_clear = 1'b0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_short_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
